// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: forwarding-mux select encodings
// and the multiply/divide scoreboard state type.
package hazard_pkg;

  localparam logic [1:0] FWD_REGFILE   = 2'b00;
  localparam logic [1:0] FWD_WRITEBACK = 2'b01;
  localparam logic [1:0] FWD_MEMORY    = 2'b10;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // Memory-stage result is newer than writeback, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic memory_hit, input logic writeback_hit);
    if (memory_hit)
      return FWD_MEMORY;
    else if (writeback_hit)
      return FWD_WRITEBACK;
    else
      return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/muldiv_scoreboard.sv
// Tracks occupancy of the multi-cycle multiply/divide unit with a down-counter.
// Busy is registered so it lines up with the counter value held that cycle.
module muldiv_scoreboard
  import hazard_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_LATENCY = (DIV_LATENCY > MULT_LATENCY) ? DIV_LATENCY : MULT_LATENCY;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY);

  md_state_t        state, next_state;
  logic [CNT_W-1:0] count, next_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= MD_IDLE;
      count <= '0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      busy  <= (next_count != '0);
    end
  end

  // A start while busy should be prevented upstream; if it happens it reloads.
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      MD_IDLE: begin
        if (start) begin
          next_count = is_div ? DIV_LOAD : MULT_LOAD;
          next_state = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (start) begin
          next_count = is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          next_count = count - CNT_W'(1);
          if (next_count == '0)
            next_state = MD_IDLE;
        end
      end
      default: begin
        next_state = MD_IDLE;
        next_count = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/muldiv interlocks,
// memory-wait freeze and a saturating count of decode-stall cycles.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32,
  parameter int COUNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  branch_decode,
  input  logic                  use_rs_decode,
  input  logic                  use_rt_decode,
  input  logic [REG_ADDR_W-1:0] Rs_decode,
  input  logic [REG_ADDR_W-1:0] Rt_decode,
  input  logic [REG_ADDR_W-1:0] Rs_execute,
  input  logic [REG_ADDR_W-1:0] Rt_execute,
  input  logic [REG_ADDR_W-1:0] write_register_execute,
  input  logic [REG_ADDR_W-1:0] write_register_memory,
  input  logic [REG_ADDR_W-1:0] write_register_writeback,
  input  logic                  register_write_execute,
  input  logic                  register_write_memory,
  input  logic                  register_write_writeback,
  input  logic                  memory_to_register_execute,
  input  logic                  memory_to_register_memory,
  input  logic                  muldiv_start_execute,
  input  logic                  muldiv_is_div_execute,
  input  logic                  muldiv_decode,
  input  logic                  hilo_access_decode,
  input  logic                  redirect_flush,
  input  logic                  memory_wait,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  stall_execute,
  output logic                  stall_memory,
  output logic                  flush_execute_register,
  output logic                  forward_register_file_output_1_decode,
  output logic                  forward_register_file_output_2_decode,
  output logic [1:0]            forward_register_file_output_1_execute,
  output logic [1:0]            forward_register_file_output_2_execute,
  output logic                  muldiv_busy,
  output logic [COUNT_W-1:0]    stall_cycle_count
);

  logic rs_mem_hit, rs_wb_hit, rt_mem_hit, rt_wb_hit;
  logic rs_dec_mem_hit, rt_dec_mem_hit;
  logic lwstall, branchstall, muldivstall, hazard_stall;
  logic rs_exe_dest_hit, rt_exe_dest_hit, rs_mem_load_hit, rt_mem_load_hit;

  muldiv_scoreboard #(
    .MULT_LATENCY(MULT_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_muldiv_scoreboard (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (muldiv_start_execute),
    .is_div (muldiv_is_div_execute),
    .busy   (muldiv_busy)
  );

  // Register $0 is hardwired to zero, so it never forwards or interlocks.
  always_comb begin
    rs_mem_hit     = (Rs_execute != '0) && (Rs_execute == write_register_memory)    && register_write_memory;
    rs_wb_hit      = (Rs_execute != '0) && (Rs_execute == write_register_writeback) && register_write_writeback;
    rt_mem_hit     = (Rt_execute != '0) && (Rt_execute == write_register_memory)    && register_write_memory;
    rt_wb_hit      = (Rt_execute != '0) && (Rt_execute == write_register_writeback) && register_write_writeback;
    rs_dec_mem_hit = (Rs_decode != '0)  && (Rs_decode == write_register_memory)     && register_write_memory;
    rt_dec_mem_hit = (Rt_decode != '0)  && (Rt_decode == write_register_memory)     && register_write_memory;

    lwstall = memory_to_register_execute && (Rt_execute != '0) &&
              ((use_rs_decode && (Rs_decode == Rt_execute)) ||
               (use_rt_decode && (Rt_decode == Rt_execute)));

    rs_exe_dest_hit = use_rs_decode && (Rs_decode == write_register_execute);
    rt_exe_dest_hit = use_rt_decode && (Rt_decode == write_register_execute);
    rs_mem_load_hit = use_rs_decode && (Rs_decode == write_register_memory);
    rt_mem_load_hit = use_rt_decode && (Rt_decode == write_register_memory);

    branchstall = branch_decode &&
                  ((register_write_execute && (write_register_execute != '0) &&
                    (rs_exe_dest_hit || rt_exe_dest_hit)) ||
                   (memory_to_register_memory && (write_register_memory != '0) &&
                    (rs_mem_load_hit || rt_mem_load_hit)));

    muldivstall  = (muldiv_decode || hilo_access_decode) && (muldiv_busy || muldiv_start_execute);
    hazard_stall = lwstall || branchstall || muldivstall;
  end

  // Memory wait freezes every stage and suppresses the bubble/redirect flush.
  always_comb begin
    stall_fetch                            = 1'b0;
    stall_decode                           = 1'b0;
    stall_execute                          = 1'b0;
    stall_memory                           = 1'b0;
    flush_execute_register                 = 1'b1;
    forward_register_file_output_1_decode  = 1'b0;
    forward_register_file_output_2_decode  = 1'b0;
    forward_register_file_output_1_execute = FWD_REGFILE;
    forward_register_file_output_2_execute = FWD_REGFILE;
    if (reset_n) begin
      forward_register_file_output_1_decode  = rs_dec_mem_hit;
      forward_register_file_output_2_decode  = rt_dec_mem_hit;
      forward_register_file_output_1_execute = fwd_select(rs_mem_hit, rs_wb_hit);
      forward_register_file_output_2_execute = fwd_select(rt_mem_hit, rt_wb_hit);
      if (memory_wait) begin
        stall_fetch            = 1'b1;
        stall_decode           = 1'b1;
        stall_execute          = 1'b1;
        stall_memory           = 1'b1;
        flush_execute_register = 1'b0;
      end else begin
        stall_fetch            = hazard_stall;
        stall_decode           = hazard_stall;
        flush_execute_register = hazard_stall || redirect_flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_cycle_count <= '0;
    else if (stall_decode && (stall_cycle_count != '1))
      stall_cycle_count <= stall_cycle_count + COUNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed expectations;
// built with a 4-bit stall counter so saturation is reachable quickly.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       branch_decode, use_rs_decode, use_rt_decode;
  logic [4:0] Rs_decode, Rt_decode, Rs_execute, Rt_execute;
  logic [4:0] write_register_execute, write_register_memory, write_register_writeback;
  logic       register_write_execute, register_write_memory, register_write_writeback;
  logic       memory_to_register_execute, memory_to_register_memory;
  logic       muldiv_start_execute, muldiv_is_div_execute, muldiv_decode, hilo_access_decode;
  logic       redirect_flush, memory_wait;
  logic       stall_fetch, stall_decode, stall_execute, stall_memory, flush_execute_register;
  logic       fwd1_decode, fwd2_decode;
  logic [1:0] fwd1_execute, fwd2_execute;
  logic       muldiv_busy;
  logic [3:0] stall_cycle_count;

  int checks = 0;
  int passes = 0;

  hazard_scoreboard_unit #(
    .REG_ADDR_W(5), .MULT_LATENCY(4), .DIV_LATENCY(32), .COUNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .branch_decode(branch_decode),
    .use_rs_decode(use_rs_decode), .use_rt_decode(use_rt_decode),
    .Rs_decode(Rs_decode), .Rt_decode(Rt_decode), .Rs_execute(Rs_execute), .Rt_execute(Rt_execute),
    .write_register_execute(write_register_execute), .write_register_memory(write_register_memory),
    .write_register_writeback(write_register_writeback),
    .register_write_execute(register_write_execute), .register_write_memory(register_write_memory),
    .register_write_writeback(register_write_writeback),
    .memory_to_register_execute(memory_to_register_execute), .memory_to_register_memory(memory_to_register_memory),
    .muldiv_start_execute(muldiv_start_execute), .muldiv_is_div_execute(muldiv_is_div_execute),
    .muldiv_decode(muldiv_decode), .hilo_access_decode(hilo_access_decode),
    .redirect_flush(redirect_flush), .memory_wait(memory_wait),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_memory(stall_memory), .flush_execute_register(flush_execute_register),
    .forward_register_file_output_1_decode(fwd1_decode), .forward_register_file_output_2_decode(fwd2_decode),
    .forward_register_file_output_1_execute(fwd1_execute), .forward_register_file_output_2_execute(fwd2_execute),
    .muldiv_busy(muldiv_busy), .stall_cycle_count(stall_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic apply_stimulus();
    branch_decode = 0; use_rs_decode = 0; use_rt_decode = 0;
    Rs_decode = 0; Rt_decode = 0; Rs_execute = 0; Rt_execute = 0;
    write_register_execute = 0; write_register_memory = 0; write_register_writeback = 0;
    register_write_execute = 0; register_write_memory = 0; register_write_writeback = 0;
    memory_to_register_execute = 0; memory_to_register_memory = 0;
    muldiv_start_execute = 0; muldiv_is_div_execute = 0; muldiv_decode = 0; hilo_access_decode = 0;
    redirect_flush = 0; memory_wait = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_setup();
    memory_to_register_execute = 1; Rt_execute = 8; Rs_decode = 8; use_rs_decode = 1;
  endtask

  initial begin
    apply_stimulus();
    reset_n = 0;
    memory_wait = 1;
    #2;
    check_output("reset_flush", flush_execute_register, 1);
    check_output("reset_stall_fetch", stall_fetch, 0);
    check_output("reset_stall_memory", stall_memory, 0);
    tick();
    check_output("reset_busy", muldiv_busy, 0);
    check_output("reset_count", stall_cycle_count, 0);
    memory_wait = 0;
    reset_n = 1;
    #1;
    check_output("idle_flush", flush_execute_register, 0);

    // Load-use interlock, lasting one cycle until the bubble reaches execute
    load_use_setup();
    #1;
    check_output("lw_stall_fetch", stall_fetch, 1);
    check_output("lw_stall_decode", stall_decode, 1);
    check_output("lw_flush", flush_execute_register, 1);
    check_output("lw_stall_execute", stall_execute, 0);
    tick();
    memory_to_register_execute = 0;
    #1;
    check_output("lw_after_stall", stall_decode, 0);
    check_output("lw_after_flush", flush_execute_register, 0);
    load_use_setup();
    use_rs_decode = 0;
    #1;
    check_output("lw_unused_rs", stall_decode, 0);
    apply_stimulus();

    // Forwarding priority
    Rs_execute = 5; Rt_execute = 5; Rs_decode = 5;
    write_register_memory = 5; register_write_memory = 1;
    write_register_writeback = 5; register_write_writeback = 1;
    #1;
    check_output("fwd1_ex_mem", fwd1_execute, 2'b10);
    check_output("fwd2_ex_mem", fwd2_execute, 2'b10);
    check_output("fwd1_dec_mem", fwd1_decode, 1);
    check_output("fwd2_dec_none", fwd2_decode, 0);
    register_write_memory = 0;
    #1;
    check_output("fwd1_ex_wb", fwd1_execute, 2'b01);
    check_output("fwd1_dec_off", fwd1_decode, 0);
    Rs_execute = 0; write_register_writeback = 0;
    #1;
    check_output("fwd1_ex_zero", fwd1_execute, 2'b00);
    apply_stimulus();

    redirect_flush = 1;
    #1;
    check_output("redirect_flush", flush_execute_register, 1);
    check_output("redirect_nostall", stall_decode, 0);
    apply_stimulus();

    // Divide interlock: div issues at cycle 0 with mflo behind it in decode
    muldiv_start_execute = 1; muldiv_is_div_execute = 1; hilo_access_decode = 1;
    #1;
    check_output("div_c0_stall", stall_decode, 1);
    check_output("div_c0_busy", muldiv_busy, 0);
    tick();
    muldiv_start_execute = 0; muldiv_is_div_execute = 0;
    #1;
    for (int c = 1; c <= 32; c++) begin
      check_output($sformatf("div_c%0d_busy", c), muldiv_busy, 1);
      check_output($sformatf("div_c%0d_stall", c), stall_decode, 1);
      tick();
    end
    check_output("div_c33_busy", muldiv_busy, 0);
    check_output("div_c33_stall", stall_decode, 0);
    apply_stimulus();

    // Multiply clears after four busy cycles
    muldiv_start_execute = 1;
    tick();
    muldiv_start_execute = 0;
    #1;
    for (int c = 1; c <= 4; c++) begin
      check_output($sformatf("mult_c%0d_busy", c), muldiv_busy, 1);
      tick();
    end
    check_output("mult_c5_busy", muldiv_busy, 0);

    // Memory freeze over a load-use stall while a multiply counts down
    load_use_setup();
    muldiv_start_execute = 1;
    tick();
    muldiv_start_execute = 0;
    memory_wait = 1; redirect_flush = 1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      check_output($sformatf("frz_c%0d_fetch", c), stall_fetch, 1);
      check_output($sformatf("frz_c%0d_execute", c), stall_execute, 1);
      check_output($sformatf("frz_c%0d_memory", c), stall_memory, 1);
      check_output($sformatf("frz_c%0d_flush", c), flush_execute_register, 0);
      check_output($sformatf("frz_c%0d_busy", c), muldiv_busy, 1);
      tick();
    end
    memory_wait = 0;
    #1;
    check_output("frz_rel_flush", flush_execute_register, 1);
    check_output("frz_rel_stall_decode", stall_decode, 1);
    check_output("frz_rel_stall_execute", stall_execute, 0);
    check_output("frz_rel_busy", muldiv_busy, 1);
    tick();
    check_output("frz_c5_busy", muldiv_busy, 0);
    apply_stimulus();

    // Saturating stall counter from a held branch stall
    reset_n = 0;
    tick();
    reset_n = 1;
    check_output("sat_start", stall_cycle_count, 0);
    branch_decode = 1; register_write_execute = 1; write_register_execute = 3;
    Rs_decode = 3; use_rs_decode = 1;
    #1;
    check_output("branch_stall", stall_decode, 1);
    for (int c = 0; c < 10; c++) tick();
    check_output("sat_mid", stall_cycle_count, 10);
    for (int c = 0; c < 10; c++) tick();
    check_output("sat_full", stall_cycle_count, 15);
    tick();
    check_output("sat_hold", stall_cycle_count, 15);
    apply_stimulus();

    // Reset while a divide has 17 cycles left
    muldiv_start_execute = 1; muldiv_is_div_execute = 1;
    tick();
    muldiv_start_execute = 0; muldiv_is_div_execute = 0;
    hilo_access_decode = 1;
    for (int c = 0; c < 15; c++) tick();
    check_output("rst_pre_busy", muldiv_busy, 1);
    check_output("rst_pre_count", stall_cycle_count, 15);
    reset_n = 0;
    Rs_execute = 5; write_register_memory = 5; register_write_memory = 1;
    #1;
    check_output("rst_flush", flush_execute_register, 1);
    check_output("rst_stall", stall_decode, 0);
    check_output("rst_fwd", fwd1_execute, 2'b00);
    tick();
    reset_n = 1;
    #1;
    check_output("rst_post_busy", muldiv_busy, 0);
    check_output("rst_post_count", stall_cycle_count, 0);
    check_output("rst_post_stall", stall_decode, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
